// File: rtl/mem_port_sched.sv
// mem_port_sched: sequences fetch and data requests onto one shared memory port,
// one command at a time, and stalls the pipeline while a request is outstanding.
module mem_port_sched #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter bit FAIR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [3:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              if_err,
  output logic              stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // IDLE arbitrates | DATA/FETCH hold a command until mem_ready | RESP pulses done
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FETCH, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_data, w_last_data_nxt;
  logic              r_mem_rd, r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [3:0]        r_mem_size;
  logic              r_if_done, r_d_done, r_if_err, r_d_err;
  logic [31:0]       r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_mem_rd_nxt, w_mem_wr_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic [3:0]        w_mem_size_nxt;
  logic              w_if_done_nxt, w_d_done_nxt, w_if_err_nxt, w_d_err_nxt;
  logic [31:0]       w_if_rdata_nxt;
  logic [DATA_W-1:0] w_d_rdata_nxt;

  logic w_sz_b, w_sz_d, w_d_bad, w_if_bad, w_grant_d, w_grant_f;

  assign w_sz_b   = (d_size == 4'b0001);
  assign w_sz_d   = (d_size == 4'b1000);
  assign w_d_bad  = (d_read == d_write) | ~(w_sz_b | w_sz_d) | (w_sz_d & (|d_addr[2:0]));
  assign w_if_bad = |if_addr[1:0];

  // On a tie, fairness hands the grant to whoever lost the previous one.
  assign w_grant_d = d_req & (~if_req | (FAIR_EN == 1'b0) | ~r_last_data);
  assign w_grant_f = if_req & ~w_grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_data <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_data <= w_last_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_data_nxt = r_last_data;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_last_data_nxt = 1'b1;
          w_state_nxt     = w_d_bad ? S_RESP : S_DATA;
        end else if (w_grant_f) begin
          w_last_data_nxt = 1'b0;
          w_state_nxt     = w_if_bad ? S_RESP : S_FETCH;
        end
      end
      S_DATA, S_FETCH: if (mem_ready) w_state_nxt = S_RESP;
      default:         w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_rd_nxt    = r_mem_rd;
    w_mem_wr_nxt    = r_mem_wr;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_size_nxt  = r_mem_size;
    w_if_done_nxt   = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_if_err_nxt    = 1'b0;
    w_d_err_nxt     = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          if (w_d_bad) begin
            w_d_done_nxt  = 1'b1;
            w_d_err_nxt   = 1'b1;
            w_d_rdata_nxt = '0;
          end else begin
            w_mem_rd_nxt    = d_read;
            w_mem_wr_nxt    = d_write;
            w_mem_addr_nxt  = d_addr;
            w_mem_size_nxt  = d_size;
            w_mem_wdata_nxt = '0;
            if (d_write)
              w_mem_wdata_nxt = w_sz_b ? {{(DATA_W-8){1'b0}}, d_wdata[7:0]} : d_wdata;
          end
        end else if (w_grant_f) begin
          if (w_if_bad) begin
            w_if_done_nxt  = 1'b1;
            w_if_err_nxt   = 1'b1;
            w_if_rdata_nxt = '0;
          end else begin
            w_mem_rd_nxt    = 1'b1;
            w_mem_wr_nxt    = 1'b0;
            w_mem_addr_nxt  = if_addr;
            w_mem_size_nxt  = 4'd4;
            w_mem_wdata_nxt = '0;
          end
        end
      end
      S_DATA, S_FETCH: begin
        if (mem_ready) begin
          w_mem_rd_nxt    = 1'b0;
          w_mem_wr_nxt    = 1'b0;
          w_mem_addr_nxt  = '0;
          w_mem_wdata_nxt = '0;
          w_mem_size_nxt  = '0;
          if (r_state == S_DATA) begin
            w_d_done_nxt  = 1'b1;
            w_d_rdata_nxt = '0;
            if (r_mem_rd)
              w_d_rdata_nxt = (r_mem_size == 4'b0001) ?
                              {{(DATA_W-8){1'b0}}, mem_rdata[7:0]} : mem_rdata;
          end else begin
            w_if_done_nxt  = 1'b1;
            w_if_rdata_nxt = mem_rdata[31:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_err     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_size  <= w_mem_size_nxt;
      r_if_done   <= w_if_done_nxt;
      r_d_done    <= w_d_done_nxt;
      r_if_err    <= w_if_err_nxt;
      r_d_err     <= w_d_err_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_size  = r_mem_size;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign if_err    = r_if_err;
  assign d_err     = r_d_err;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall     = (if_req & ~r_if_done) | (d_req & ~r_d_done);

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: directed and random requests, a memory
// responder checking commands, and a monitor checking every done pulse.
module tb_mem_port_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req, if_done, if_err, d_req, d_read, d_write, d_done, d_err, stall;
  logic        mem_rd, mem_wr, mem_ready;
  logic [63:0] if_addr, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] if_rdata;
  logic [3:0]  d_size, mem_size;

  mem_port_sched #(.ADDR_W(64), .DATA_W(64), .FAIR_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_read(d_read), .d_write(d_write), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .d_err(d_err), .if_err(if_err), .stall(stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Second instance with FAIR_EN=0, driven only by the priority tie test.
  logic        if_req0, d_req0, if_done0, if_err0, d_done0, d_err0, stall0, mem_rd0, mem_wr0;
  logic [31:0] if_rdata0;
  logic [63:0] d_rdata0, mem_addr0, mem_wdata0;
  logic [3:0]  mem_size0;

  mem_port_sched #(.ADDR_W(64), .DATA_W(64), .FAIR_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req0), .if_addr(64'h0), .if_rdata(if_rdata0), .if_done(if_done0),
    .d_req(d_req0), .d_read(1'b1), .d_write(1'b0), .d_size(4'b1000),
    .d_addr(64'h10), .d_wdata(64'h0), .d_rdata(d_rdata0), .d_done(d_done0),
    .d_err(d_err0), .if_err(if_err0), .stall(stall0),
    .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_size(mem_size0), .mem_rdata(64'h0), .mem_ready(1'b1)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
  } cmd_t;
  typedef struct {
    bit          is_data;
    bit          err;
    logic [63:0] rdata;
  } done_t;

  cmd_t  cmd_q[$];
  done_t done_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    m_last_data = 1'b0;
  bit    ovr_en = 1'b0;
  logic [63:0] ovr_val = '0;
  int    fixed_wait = -1;
  bit    mon_en = 1'b0;

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (ovr_en) return ovr_val;
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F1E_2D3C_4B5A_6978;
  endfunction

  function automatic void exp_data(input logic rd, input logic wr, input logic [3:0] sz,
                                   input logic [63:0] a, input logic [63:0] wd);
    cmd_t c;
    done_t d;
    logic [63:0] v;
    bit ok;
    ok = (rd != wr) && (sz == 4'b0001 || sz == 4'b1000) && !(sz == 4'b1000 && a[2:0] != 3'b0);
    d.is_data = 1'b1;
    d.err     = !ok;
    d.rdata   = '0;
    if (ok) begin
      c.rd = rd; c.wr = wr; c.addr = a; c.size = sz;
      c.wdata = (sz == 4'b0001) ? {56'h0, wd[7:0]} : wd;
      cmd_q.push_back(c);
      v = mem_val(a);
      if (rd) d.rdata = (sz == 4'b0001) ? {56'h0, v[7:0]} : v;
    end
    done_q.push_back(d);
  endfunction

  function automatic void exp_fetch(input logic [63:0] a);
    cmd_t c;
    done_t d;
    logic [63:0] v;
    d.is_data = 1'b0;
    d.err     = (a[1:0] != 2'b0);
    d.rdata   = '0;
    if (!d.err) begin
      c.rd = 1'b1; c.wr = 1'b0; c.addr = a; c.size = 4'd4; c.wdata = '0;
      cmd_q.push_back(c);
      v = mem_val(a);
      d.rdata = {32'h0, v[31:0]};
    end
    done_q.push_back(d);
  endfunction

  task automatic wait_done(input bit use_d, input bit use_f);
    bit pd, pf, kd, kf;
    pd = use_d; pf = use_f; kd = 1'b0; kf = 1'b0;
    for (int c = 0; c < 400 && (pd || pf || kd || kf); c++) begin
      @(posedge clk); #1;
      if (kd) begin d_req = 1'b0; kd = 1'b0; end
      if (kf) begin if_req = 1'b0; kf = 1'b0; end
      if (pd && d_done)  begin pd = 1'b0; kd = 1'b1; end
      if (pf && if_done) begin pf = 1'b0; kf = 1'b1; end
    end
    n_cmp++;
    if (pd || pf) begin
      n_fail++;
      $display("FAIL round_timeout: data pending=%b fetch pending=%b, required both completed", pd, pf);
      d_req = 1'b0; if_req = 1'b0;
    end
  endtask

  task automatic do_round(input bit use_d, input bit use_f, input logic rd, input logic wr,
                          input logic [3:0] sz, input logic [63:0] da, input logic [63:0] wd,
                          input logic [63:0] fa);
    bit first_d;
    @(posedge clk); #1;
    d_read = rd; d_write = wr; d_size = sz; d_addr = da; d_wdata = wd; if_addr = fa;
    first_d = use_d && (!use_f || !m_last_data);
    if (first_d) begin
      exp_data(rd, wr, sz, da, wd);
      if (use_f) exp_fetch(fa);
    end else begin
      if (use_f) exp_fetch(fa);
      if (use_d) exp_data(rd, wr, sz, da, wd);
    end
    if (use_d && use_f) m_last_data = !first_d;
    else if (use_d)     m_last_data = 1'b1;
    else if (use_f)     m_last_data = 1'b0;
    d_req = use_d; if_req = use_f;
    wait_done(use_d, use_f);
  endtask

  task automatic rand_round();
    int k, op, ss;
    logic rd, wr;
    logic [3:0] sz;
    logic [63:0] da, fa, wd;
    k  = $urandom_range(0, 2);
    op = $urandom_range(0, 9);
    rd = (op < 4) || (op == 9);
    wr = (op >= 4 && op < 8) || (op == 9);
    ss = $urandom_range(0, 9);
    sz = (ss < 5) ? 4'b0001 : (ss < 9) ? 4'b1000 : 4'($urandom);
    da = {$urandom, $urandom};
    if (sz == 4'b1000 && $urandom_range(0, 3) != 0) da[2:0] = 3'b0;
    fa = {$urandom, $urandom};
    if ($urandom_range(0, 5) != 0) fa[1:0] = 2'b0;
    wd = {$urandom, $urandom};
    repeat ($urandom_range(0, 1)) @(posedge clk);
    do_round(k != 1, k != 0, rd, wr, sz, da, wd, fa);
  endtask

  // Monitor: pops the scoreboard whenever a done pulse is visible.
  done_t mon_e;
  bit    mon_ok;
  logic  mon_exp_stall;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      mon_exp_stall = d_done ? if_req : (if_done ? d_req : (if_req | d_req));
      n_cmp++;
      if (stall !== mon_exp_stall || (d_err && !d_done) || (if_err && !if_done)) begin
        n_fail++;
        $display("FAIL stall_err t=%0t: stall=%b d_err=%b if_err=%b, required stall=%b and errors only with done",
                 $time, stall, d_err, if_err, mon_exp_stall);
      end
      if (d_done || if_done) begin
        n_cmp++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done t=%0t: d_done=%b if_done=%b, required none", $time, d_done, if_done);
        end else begin
          mon_e = done_q.pop_front();
          if (mon_e.is_data)
            mon_ok = (d_done === 1'b1) && (if_done === 1'b0) && (d_err === mon_e.err) && (d_rdata === mon_e.rdata);
          else
            mon_ok = (if_done === 1'b1) && (d_done === 1'b0) && (if_err === mon_e.err) && (if_rdata === mon_e.rdata[31:0]);
          if (!mon_ok) begin
            n_fail++;
            $display("FAIL done t=%0t: d_done=%b if_done=%b d_err=%b if_err=%b d_rdata=%h if_rdata=%h, required data=%b err=%b rdata=%h",
                     $time, d_done, if_done, d_err, if_err, d_rdata, if_rdata, mon_e.is_data, mon_e.err, mon_e.rdata);
          end
        end
      end
    end
  end

  // Memory responder: checks every command cycle and answers after a random wait.
  cmd_t rsp_cur;
  bit   rsp_have = 1'b0;
  bit   rsp_ok;
  int   rsp_cnt = 0;
  int   rsp_wt = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        rsp_cnt = 0; mem_ready = 1'b0;
      end else if (mem_rd || mem_wr) begin
        if (rsp_cnt == 0) begin
          n_cmp++;
          if (cmd_q.size() == 0) begin
            n_fail++; rsp_have = 1'b0;
            $display("FAIL unexpected_cmd t=%0t: mem_rd=%b mem_wr=%b addr=%h, required no command", $time, mem_rd, mem_wr, mem_addr);
          end else begin
            rsp_cur = cmd_q.pop_front(); rsp_have = 1'b1;
          end
          rsp_wt = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
        end
        if (rsp_have) begin
          n_cmp++;
          rsp_ok = (mem_rd === rsp_cur.rd) && (mem_wr === rsp_cur.wr) && (mem_addr === rsp_cur.addr) &&
                   (mem_size === rsp_cur.size) && (!rsp_cur.wr || mem_wdata === rsp_cur.wdata);
          if (!rsp_ok) begin
            n_fail++;
            $display("FAIL cmd t=%0t: rd=%b wr=%b addr=%h size=%h wdata=%h, required rd=%b wr=%b addr=%h size=%h wdata=%h",
                     $time, mem_rd, mem_wr, mem_addr, mem_size, mem_wdata,
                     rsp_cur.rd, rsp_cur.wr, rsp_cur.addr, rsp_cur.size, rsp_cur.wdata);
          end
        end
        mem_rdata = mem_val(mem_addr);
        mem_ready = (rsp_cnt == rsp_wt);
        rsp_cnt   = mem_ready ? 0 : rsp_cnt + 1;
      end else begin
        if (rsp_cnt != 0) begin
          n_cmp++; n_fail++;
          $display("FAIL cmd_dropped t=%0t: command gone after %0d cycles, required hold until mem_ready", $time, rsp_cnt);
        end
        rsp_cnt   = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int  n_d0, n_f0;
  bit  seen;
  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    d_size = '0; d_addr = '0; d_wdata = '0;
    if_req0 = 1'b0; d_req0 = 1'b0;
    #2;
    n_cmp++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata, mem_size, if_done, d_done, if_err, d_err,
         if_rdata, d_rdata, stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%b wr=%b addr=%h wdata=%h size=%h done=%b%b err=%b%b rdata=%h/%h stall=%b, required all 0",
               mem_rd, mem_wr, mem_addr, mem_wdata, mem_size, if_done, d_done, if_err, d_err, if_rdata, d_rdata, stall);
    end
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; mon_en = 1'b1;

    // Strict data priority: both held, data completes every third cycle, fetch never.
    @(posedge clk); #1;
    if_req0 = 1'b1; d_req0 = 1'b1;
    n_d0 = 0; n_f0 = 0;
    repeat (30) begin
      @(negedge clk);
      if (d_done0)  n_d0++;
      if (if_done0) n_f0++;
    end
    @(posedge clk); #1;
    if_req0 = 1'b0; d_req0 = 1'b0;
    n_cmp++;
    if (n_f0 != 0) begin n_fail++; $display("FAIL prio_fetch: if_done count=%0d, required 0", n_f0); end
    n_cmp++;
    if (n_d0 != 10) begin n_fail++; $display("FAIL prio_data: d_done count=%0d, required 10", n_d0); end

    fixed_wait = 1; ovr_en = 1'b1; ovr_val = 64'hFFFF_FFFF_8B02_0020;
    do_round(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 64'h0, 64'h0, 64'h40);
    fixed_wait = -1; ovr_val = 64'hAABB_CCDD_EEFF_1234;
    do_round(1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 64'h13, 64'h0, 64'h0);
    ovr_en = 1'b0;
    do_round(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0);
    do_round(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0);
    do_round(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 64'h18, 64'h0, 64'h0);
    do_round(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 64'h8, 64'h0, 64'h0);
    do_round(1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 64'h8, 64'h0, 64'h0);
    do_round(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 64'h4, 64'h0, 64'h0);
    do_round(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 64'h8, 64'h0, 64'h0);
    do_round(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 64'h0, 64'h0, 64'h42);
    repeat (4) do_round(1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 64'h20, 64'h0, 64'h100);

    for (int i = 0; i < 150; i++) rand_round();

    // Reset while a fetch waits on mem_ready, then restart with the request still high.
    fixed_wait = 1000;
    @(posedge clk); #1;
    if_addr = 64'h80;
    exp_fetch(64'h80);
    if_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_rd) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL rst_cmd_start: mem_rd=%b, required 1 before reset", mem_rd); end
    @(posedge clk); #3;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_rd !== 1'b0 || if_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: mem_rd=%b if_done=%b, required 0 0 without a clock edge", mem_rd, if_done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_rd !== 1'b0 || if_done !== 1'b0 || if_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: mem_rd=%b if_done=%b if_err=%b, required 0 0 0", mem_rd, if_done, if_err);
    end
    done_q.delete();
    cmd_q.delete();
    fixed_wait = -1;
    m_last_data = 1'b0;
    exp_fetch(64'h80);
    reset = 1'b0;
    mon_en = 1'b1;
    wait_done(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    n_cmp++;
    if (done_q.size() != 0 || cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: done entries=%0d cmd entries=%0d, required 0 0", done_q.size(), cmd_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
